// File: rtl/updown_sweep_ctrl.sv
// Purpose : sequences an up/down counter so it sweeps between captured lo/hi limits for n full sweeps.
// Latency : start accepted -> o_sclr next cycle; o_done and o_err pulse one cycle after the deciding edge.
// Backpr. : i_hold freezes the sequence and drops o_en; i_abort drops o_en at once and returns to IDLE.
//
// Ports:
//   i_clk, i_rst_n      clock shared with the counter; asynchronous active-low reset
//   i_start             start request, only looked at in IDLE
//   i_abort, i_hold     abort the run / pause it (abort has priority)
//   i_lo, i_hi          sweep limits, captured on an accepted start
//   i_nsweeps           number of up+down sweeps, captured on an accepted start
//   i_cnt               count value fed back from the counter
//   o_up_down           counter direction (1 = up), registered
//   o_en                counter enable, combinational
//   o_sclr              counter synchronous clear, registered
//   o_busy              high outside IDLE
//   o_done              one-cycle pulse on normal completion
//   o_err               one-cycle pulse when a start is rejected
//   o_sweep_cnt         sweeps completed in the current or last run

module updown_sweep_ctrl #(
  parameter int BUS_WIDTH   = 4,
  parameter int SWEEP_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_hold,
  input  logic [BUS_WIDTH-1:0]   i_lo,
  input  logic [BUS_WIDTH-1:0]   i_hi,
  input  logic [SWEEP_WIDTH-1:0] i_nsweeps,
  input  logic [BUS_WIDTH-1:0]   i_cnt,
  output logic                   o_up_down,
  output logic                   o_en,
  output logic                   o_sclr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [SWEEP_WIDTH-1:0] o_sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_SEEK    = 3'd2,
    S_UP      = 3'd3,
    S_TURN_DN = 3'd4,
    S_DOWN    = 3'd5,
    S_TURN_UP = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   lo_q, lo_d;
  logic [BUS_WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_WIDTH-1:0] n_q, n_d;
  logic [SWEEP_WIDTH-1:0] sweep_q, sweep_d;
  logic [SWEEP_WIDTH-1:0] sweep_nxt;
  logic                   up_down_q, up_down_d;
  logic                   sclr_q, sclr_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   start_ok;
  logic                   at_lo;
  logic                   at_hi;
  logic                   en_term;

  assign start_ok = (i_lo <= i_hi) && (i_nsweeps != '0);
  assign at_lo    = (i_cnt == lo_q);
  assign at_hi    = (i_cnt == hi_q);

  // Enable is purely a function of the current state and the fed-back count,
  // so the counter stops on the very edge it reaches a limit.
  always_comb begin
    en_term = 1'b0;
    case (state_q)
      S_SEEK:  en_term = !at_lo;
      S_UP:    en_term = !at_hi;
      S_DOWN:  en_term = !at_lo;
      default: en_term = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    n_d       = n_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sweep_nxt = sweep_q + SWEEP_WIDTH'(1);

    if (state_q == S_IDLE) begin
      // Abort has no meaning in IDLE, so a start alongside it still goes.
      if (i_start) begin
        if (start_ok) begin
          lo_d    = i_lo;
          hi_d    = i_hi;
          n_d     = i_nsweeps;
          sweep_d = '0;
          state_d = S_CLR;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (i_abort) begin
      state_d = S_IDLE;
    end else if (!i_hold) begin
      case (state_q)
        S_CLR:     state_d = S_SEEK;
        S_SEEK:    if (at_lo) state_d = S_UP;
        S_UP:      if (at_hi) state_d = S_TURN_DN;
        S_TURN_DN: state_d = S_DOWN;
        S_DOWN: begin
          if (at_lo) begin
            sweep_d = sweep_nxt;
            if (sweep_nxt == n_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_TURN_UP;
            end
          end
        end
        S_TURN_UP: state_d = S_UP;
        default:   state_d = S_IDLE;
      endcase
    end

    // Direction only moves on entry to a turn (or back to IDLE), giving the
    // counter a dead cycle to register it before it is enabled again. A held
    // state keeps its own value, so hold freezes these too.
    up_down_d = up_down_q;
    case (state_d)
      S_TURN_DN:         up_down_d = 1'b0;
      S_TURN_UP, S_IDLE: up_down_d = 1'b1;
      default:           up_down_d = up_down_q;
    endcase

    // Clear is asserted for every cycle spent in CLR, including held ones.
    sclr_d = (state_d == S_CLR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweep_q   <= '0;
      up_down_q <= 1'b1;
      sclr_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      n_q       <= n_d;
      sweep_q   <= sweep_d;
      up_down_q <= up_down_d;
      sclr_q    <= sclr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_en        = en_term && !i_hold && !i_abort;
  assign o_up_down   = up_down_q;
  assign o_sclr      = sclr_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_sweep_cnt = sweep_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic       i_hold;
  logic [3:0] i_lo;
  logic [3:0] i_hi;
  logic [7:0] i_nsweeps;
  logic [3:0] i_cnt;
  logic       o_up_down;
  logic       o_en;
  logic       o_sclr;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [7:0] o_sweep_cnt;

  updown_sweep_ctrl #(.BUS_WIDTH(4), .SWEEP_WIDTH(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_hold      (i_hold),
    .i_lo        (i_lo),
    .i_hi        (i_hi),
    .i_nsweeps   (i_nsweeps),
    .i_cnt       (i_cnt),
    .o_up_down   (o_up_down),
    .o_en        (o_en),
    .o_sclr      (o_sclr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_sweep_cnt (o_sweep_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Up/down counter model: direction registered one edge before use,
  // clear honoured only while the registered direction is up.
  logic [3:0] cnt_q;
  logic       dir_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 4'd0;
      dir_q <= 1'b1;
    end else begin
      dir_q <= o_up_down;
      if (o_sclr && dir_q)
        cnt_q <= 4'd0;
      else if (o_en)
        cnt_q <= dir_q ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
  end
  assign i_cnt = cnt_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-cycle log of one run, cycle 0 = the cycle i_start is driven.
  int l_cnt  [0:99];
  int l_en   [0:99];
  int l_sclr [0:99];
  int l_ud   [0:99];
  int l_busy [0:99];
  int l_done [0:99];
  int l_err  [0:99];
  int l_sw   [0:99];
  int done_cyc;
  int n_done;
  int hold_from  = -1;
  int hold_len   = 0;
  int abort_at   = -1;
  int restart_at = -1;
  int exp_seq [9] = '{0, 1, 2, 3, 4, 5, 4, 3, 2};

  task automatic run(input int lo, input int hi, input int n, input int max_cyc);
    done_cyc  = -1;
    n_done    = 0;
    i_lo      = lo[3:0];
    i_hi      = hi[3:0];
    i_nsweeps = n[7:0];
    i_start   = 1'b1;
    i_hold    = 1'b0;
    i_abort   = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge i_clk);
      l_cnt[c]  = i_cnt;
      l_en[c]   = o_en;
      l_sclr[c] = o_sclr;
      l_ud[c]   = o_up_down;
      l_busy[c] = o_busy;
      l_done[c] = o_done;
      l_err[c]  = o_err;
      l_sw[c]   = o_sweep_cnt;
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge i_clk);
      #1;
      i_start = (c + 1 == restart_at);
      if (c + 1 == restart_at) begin
        i_lo      = 4'd0;
        i_hi      = 4'd1;
        i_nsweeps = 8'd3;
      end
      i_hold  = (hold_from >= 0) && (c + 1 >= hold_from) && (c + 1 < hold_from + hold_len);
      i_abort = (c + 1 == abort_at);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    i_start    = 1'b0;
    i_hold     = 1'b0;
    i_abort    = 1'b0;
    hold_from  = -1;
    abort_at   = -1;
    restart_at = -1;
  endtask

  initial begin
    int seq[$];
    int cnt_tmp;
    int first7;

    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_hold    = 1'b0;
    i_lo      = 4'd0;
    i_hi      = 4'd0;
    i_nsweeps = 8'd0;

    // Reset values
    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_en, 0);
    chk("rst_ud", o_up_down, 1);
    chk("rst_sclr", o_sclr, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_sweep", o_sweep_cnt, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic run lo=2 hi=5 n=1
    run(2, 5, 1, 30);
    chk("basic_sclr0", l_sclr[0], 0);
    chk("basic_sclr1", l_sclr[1], 1);
    chk("basic_sclr2", l_sclr[2], 0);
    chk("basic_en1", l_en[1], 0);
    chk("basic_seek_en2", l_en[2], 1);
    chk("basic_seek_en3", l_en[3], 1);
    chk("basic_seek_en4", l_en[4], 0);
    for (int c = 5; c <= 7; c++) chk("basic_up_en", l_en[c], 1);
    chk("basic_up_en8", l_en[8], 0);
    chk("basic_turn_ud9", l_ud[9], 0);
    chk("basic_turn_en9", l_en[9], 0);
    for (int c = 10; c <= 12; c++) chk("basic_dn_en", l_en[c], 1);
    chk("basic_dn_en13", l_en[13], 0);
    chk("basic_done_cyc", done_cyc, 14);
    chk("basic_sweep", l_sw[14], 1);
    chk("basic_busy_done", l_busy[14], 0);
    seq.delete();
    seq.push_back(l_cnt[0]);
    for (int c = 1; c <= done_cyc; c++)
      if (l_cnt[c] != seq[seq.size() - 1]) seq.push_back(l_cnt[c]);
    chk("basic_seq_len", seq.size(), 9);
    if (seq.size() == 9)
      for (int k = 0; k < 9; k++) chk("basic_seq", seq[k], exp_seq[k]);
    cnt_tmp = 0;
    for (int c = 4; c <= done_cyc; c++)
      if (l_cnt[c] < 2 || l_cnt[c] > 5) cnt_tmp++;
    chk("basic_range_viol", cnt_tmp, 0);

    // Multi-sweep lo=0 hi=3 n=3
    run(0, 3, 3, 60);
    chk("multi_sw_before", l_sw[0], 1);
    chk("multi_sw_cleared", l_sw[1], 0);
    seq.delete();
    for (int c = 2; c <= done_cyc; c++)
      if (l_sw[c] != l_sw[c - 1]) seq.push_back(l_sw[c]);
    chk("multi_sw_steps", seq.size(), 3);
    if (seq.size() == 3)
      for (int k = 0; k < 3; k++) chk("multi_sw_val", seq[k], k + 1);
    cnt_tmp = 0;
    for (int c = 1; c <= done_cyc; c++)
      if (l_cnt[c] == 3 && l_cnt[c - 1] != 3) cnt_tmp++;
    chk("multi_peaks", cnt_tmp, 3);
    chk("multi_ndone", n_done, 1);
    chk("multi_done_cyc", done_cyc, 32);
    if (done_cyc > 0) begin
      chk("multi_busy_pre", l_busy[done_cyc - 1], 1);
      chk("multi_busy_done", l_busy[done_cyc], 0);
    end

    // Abort in the second DOWN of n=4 (lo=0 hi=3), cnt=2 at cycle 19
    abort_at = 19;
    run(0, 3, 4, 24);
    chk("abort_en_before", l_en[18], 1);
    chk("abort_cnt", l_cnt[19], 2);
    chk("abort_en_same", l_en[19], 0);
    chk("abort_busy_next", l_busy[20], 0);
    chk("abort_ud_next", l_ud[20], 1);
    chk("abort_sweep", l_sw[20], 1);
    chk("abort_cnt_next", l_cnt[20], 2);
    chk("abort_ndone", n_done, 0);

    // Hold for 5 cycles mid-UP at cnt=3
    hold_from = 6;
    hold_len  = 5;
    run(2, 5, 1, 40);
    chk("hold_en5", l_en[5], 1);
    for (int c = 6; c <= 10; c++) begin
      chk("hold_en", l_en[c], 0);
      chk("hold_cnt", l_cnt[c], 3);
    end
    chk("hold_en11", l_en[11], 1);
    chk("hold_done_cyc", done_cyc, 19);
    chk("hold_sweep", o_sweep_cnt, 1);

    // Rejected starts
    run(6, 4, 1, 4);
    chk("rej_lohi_err0", l_err[0], 0);
    chk("rej_lohi_err1", l_err[1], 1);
    chk("rej_lohi_err2", l_err[2], 0);
    cnt_tmp = 0;
    for (int c = 0; c < 4; c++) cnt_tmp += l_busy[c];
    chk("rej_lohi_busy", cnt_tmp, 0);
    run(2, 5, 0, 4);
    chk("rej_n0_err1", l_err[1], 1);
    chk("rej_n0_err2", l_err[2], 0);
    cnt_tmp = 0;
    for (int c = 0; c < 4; c++) cnt_tmp += l_busy[c];
    chk("rej_n0_busy", cnt_tmp, 0);

    // Start (with new limits) while busy is ignored
    restart_at = 6;
    run(2, 5, 1, 30);
    chk("busy_start_done_cyc", done_cyc, 14);
    chk("busy_start_sweep", o_sweep_cnt, 1);
    chk("busy_start_ndone", n_done, 1);
    cnt_tmp = 0;
    for (int c = 0; c <= done_cyc; c++) cnt_tmp += l_err[c];
    chk("busy_start_err", cnt_tmp, 0);

    // lo == hi == 7, n=2
    run(7, 7, 2, 40);
    chk("eq_done_cyc", done_cyc, 17);
    chk("eq_sweep", o_sweep_cnt, 2);
    first7 = -1;
    for (int c = 2; c <= done_cyc; c++)
      if (first7 < 0 && l_cnt[c] == 7) first7 = c;
    chk("eq_first7", first7, 9);
    cnt_tmp = 0;
    for (int c = 9; c <= done_cyc; c++)
      if (l_cnt[c] != 7) cnt_tmp++;
    chk("eq_cnt_const", cnt_tmp, 0);
    cnt_tmp = 0;
    for (int c = 0; c <= done_cyc; c++) cnt_tmp += l_en[c];
    chk("eq_en_cycles", cnt_tmp, 7);

    // Full range lo=0 hi=15: no wrap
    run(0, 15, 1, 60);
    chk("full_done_cyc", done_cyc, 36);
    chk("full_sweep", o_sweep_cnt, 1);
    cnt_tmp = 0;
    first7 = 0;
    for (int c = 1; c <= done_cyc; c++) begin
      if ((l_cnt[c - 1] == 15 && l_cnt[c] == 0) || (l_cnt[c - 1] == 0 && l_cnt[c] == 15)) cnt_tmp++;
      if (l_cnt[c] > first7) first7 = l_cnt[c];
    end
    chk("full_wraps", cnt_tmp, 0);
    chk("full_max", first7, 15);

    // Reset mid-DOWN of the second sweep (lo=2 hi=5 n=2)
    run(2, 5, 2, 21);
    chk("rstmid_busy_pre", l_busy[20], 1);
    chk("rstmid_sw_pre", l_sw[20], 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_en", o_en, 0);
    chk("rstmid_ud", o_up_down, 1);
    chk("rstmid_sclr", o_sclr, 0);
    chk("rstmid_done", o_done, 0);
    chk("rstmid_err", o_err, 0);
    chk("rstmid_sweep", o_sweep_cnt, 0);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run(2, 5, 1, 30);
    chk("post_rst_done_cyc", done_cyc, 14);
    chk("post_rst_sweep", o_sweep_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
